pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Drives the load enable and bubble-insert controls of the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Resolves load-use hazards, taken-branch/jump flushes and multi-cycle data-memory waits.
- Watchdogs memory waits with a timeout error state.

Parameters:
- MEM_TIMEOUT, 255: max cycles spent in MEM_WAIT before ERROR; 0 disables the timeout.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs1  in  5  RS_One of the instruction in ID.
- id_rs2  in  5  RS_Two of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- idex_memread  in  1  MemRead field of the ID/EX register.
- idex_rd  in  5  rd field of the ID/EX register.
- ex_redirect  in  1  branch taken or jump/jalr resolved in EX.
- exmem_memreq  in  1  MemRead | MemWrite of the EX/MEM register.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC load enable.
- pc_redirect  out  1  PC selects the EX target.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  buffer register load enables.
- ifid_flush, idex_flush  out  1 each  load zero (bubble) into the register instead of its input.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Registered state, wait_cnt and mem_timeout.
- All control outputs are combinational from state and inputs, so hazards act in the detection cycle.
- While reset is low, outputs are forced: all enables 0, ifid_flush=1, idex_flush=1, pc_redirect=0.
- On the reset clock edge: state=RUN, wait_cnt=0, mem_timeout=0, counters 0.
- Reset mid-MEM_WAIT or in ERROR returns to RUN on that edge.
- RUN default: all enables 1, flushes 0, pc_redirect 0.
- RUN, priority 1, mem stall (exmem_memreq & !dmem_ready):
  - All enables 0 and all flushes 0; whole pipe frozen.
  - Next state MEM_WAIT, wait_cnt=1.
  - Overrides redirect and load-use in the same cycle.
- RUN, priority 2, redirect (ex_redirect):
  - pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1; other enables 1.
  - Squashes any load-use stall in the same cycle.
- RUN, priority 3, load-use: idex_memread & idex_rd!=0 & ((id_rs1_used & id_rs1==idex_rd) | (id_rs2_used & id_rs2==idex_rd)).
  - pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance.
  - Exactly one bubble; no state change.
- MEM_WAIT, dmem_ready=0:
  - Pipe frozen as above; wait_cnt increments.
  - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT, next state ERROR.
- MEM_WAIT, dmem_ready=1:
  - The RUN rules for redirect and load-use apply in this cycle; mem stall is ignored.
  - Next state RUN, wait_cnt=0.
  - A branch held frozen in EX therefore flushes on the release cycle.
- ERROR: all enables 0, flushes 0, mem_timeout=1; held until reset.
- wait_cnt width is $clog2(MEM_TIMEOUT+2) and never wraps.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, adds two outputs, each CNT_W bits wide, saturating at all-ones and cleared by reset:
  - stall_cycles: +1 per cycle with pc_en=0 in RUN or MEM_WAIT.
  - flush_events: +1 per cycle with pc_redirect=1.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset low for 2 cycles with random inputs -> enables 0, ifid_flush=idex_flush=1. After release with no hazards -> all enables 1, mem_timeout=0.
- idex_memread=1, idex_rd=5, id_rs2=5, id_rs2_used=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only. Same stimulus with idex_rd=0 -> no stall.
- ex_redirect=1 coincident with a load-use condition -> pc_redirect=1, ifid_flush=idex_flush=1, ifid_en=1 (load-use suppressed).
- exmem_memreq=1, dmem_ready low 3 cycles then high, ex_redirect=1 throughout -> 3 cycles of all enables 0; release cycle has pc_redirect=1 and both flushes; state returns to RUN.
- MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR after 4 MEM_WAIT cycles, mem_timeout=1 sticky. A later dmem_ready=1 has no effect; reset low clears it.
- PIPE_PERF_CNT_EN defined, CNT_W=4, 20 consecutive stall cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: hazard sources from the pipeline and the stall/flush
// controls back to the PC and the four pipeline buffer registers.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       idex_memread;
  logic [4:0] idex_rd;
  logic       ex_redirect;
  logic       exmem_memreq;
  logic       dmem_ready;
  logic       pc_en;
  logic       pc_redirect;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, idex_memread, idex_rd,
           ex_redirect, exmem_memreq, dmem_ready,
    input  pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, idex_memread, idex_rd,
           ex_redirect, exmem_memreq, dmem_ready,
    output pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a memory-wait watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);
  localparam int unsigned       WAIT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;

  logic load_use_s;
  logic freeze_s;
  logic pc_en_s, pc_redirect_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
  logic ifid_flush_s, idex_flush_s;

  assign load_use_s = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                      ((bus.id_rs1_used && (bus.id_rs1 == bus.idex_rd)) ||
                       (bus.id_rs2_used && (bus.id_rs2 == bus.idex_rd)));

  // While waiting, only dmem_ready releases the freeze; the request may already be gone.
  assign freeze_s = (state_r == ST_MEM_WAIT) ? !bus.dmem_ready
                                             : (bus.exmem_memreq && !bus.dmem_ready);

  // Combinational control so every hazard acts in the cycle it is detected.
  always_comb begin
    pc_en_s       = 1'b0;
    pc_redirect_s = 1'b0;
    ifid_en_s     = 1'b0;
    idex_en_s     = 1'b0;
    exmem_en_s    = 1'b0;
    memwb_en_s    = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    if (!reset) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else begin
      case (state_r)
        ST_RUN, ST_MEM_WAIT: begin
          if (freeze_s) begin
            pc_en_s = 1'b0;
          end else if (bus.ex_redirect) begin
            pc_en_s       = 1'b1;
            pc_redirect_s = 1'b1;
            ifid_en_s     = 1'b1;
            idex_en_s     = 1'b1;
            exmem_en_s    = 1'b1;
            memwb_en_s    = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
          end else if (load_use_s) begin
            idex_en_s     = 1'b1;
            exmem_en_s    = 1'b1;
            memwb_en_s    = 1'b1;
            idex_flush_s  = 1'b1;
          end else begin
            pc_en_s       = 1'b1;
            ifid_en_s     = 1'b1;
            idex_en_s     = 1'b1;
            exmem_en_s    = 1'b1;
            memwb_en_s    = 1'b1;
          end
        end
        ST_ERROR: begin
          pc_en_s = 1'b0;
        end
        default: begin
          pc_en_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.exmem_memreq && !bus.dmem_ready) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end else begin
            if (wait_cnt_r != WAIT_MAX) begin
              wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
            if ((MEM_TIMEOUT != 32'd0) && (wait_cnt_r == WAIT_LIMIT)) begin
              state_r       <= ST_ERROR;
              mem_timeout_r <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          mem_timeout_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_RUN;
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.pc_en       = pc_en_s;
  assign bus.pc_redirect = pc_redirect_s;
  assign bus.ifid_en     = ifid_en_s;
  assign bus.idex_en     = idex_en_s;
  assign bus.exmem_en    = exmem_en_s;
  assign bus.memwb_en    = memwb_en_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.idex_flush  = idex_flush_s;
  assign bus.mem_timeout = mem_timeout_r;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en_s && (state_r != ST_ERROR) && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (pc_redirect_s && (flush_events != CNT_MAX)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end
`else
  logic unused_cnt_w_s;
  assign unused_cnt_w_s = (CNT_W != 32'd0);
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control vector order is
// {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}.
module tb_pipe_hazard_ctrl;
  localparam logic [7:0] C_RESET  = 8'b0000_0011;
  localparam logic [7:0] C_RUN    = 8'b1011_1100;
  localparam logic [7:0] C_LDUSE  = 8'b0001_1101;
  localparam logic [7:0] C_REDIR  = 8'b1111_1111;
  localparam logic [7:0] C_FROZEN = 8'b0000_0000;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [3:0] stall_cycles;
  logic [3:0] flush_events;
`endif

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctl();
    return {bus.pc_en, bus.pc_redirect, bus.ifid_en, bus.idex_en,
            bus.exmem_en, bus.memwb_en, bus.ifid_flush, bus.idex_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs1       = 5'd0;
    bus.id_rs2       = 5'd0;
    bus.id_rs1_used  = 1'b0;
    bus.id_rs2_used  = 1'b0;
    bus.idex_memread = 1'b0;
    bus.idex_rd      = 5'd0;
    bus.ex_redirect  = 1'b0;
    bus.exmem_memreq = 1'b0;
    bus.dmem_ready   = 1'b1;
  endtask

  task automatic random_inputs();
    bus.id_rs1       = 5'($urandom_range(31, 0));
    bus.id_rs2       = 5'($urandom_range(31, 0));
    bus.id_rs1_used  = 1'($urandom_range(1, 0));
    bus.id_rs2_used  = 1'($urandom_range(1, 0));
    bus.idex_memread = 1'($urandom_range(1, 0));
    bus.idex_rd      = 5'($urandom_range(31, 0));
    bus.ex_redirect  = 1'($urandom_range(1, 0));
    bus.exmem_memreq = 1'($urandom_range(1, 0));
    bus.dmem_ready   = 1'($urandom_range(1, 0));
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.idex_memread = 1'b1;
    bus.idex_rd      = rd;
    bus.id_rs2       = 5'd5;
    bus.id_rs2_used  = 1'b1;
    bus.id_rs1       = 5'd3;
    bus.id_rs1_used  = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held for two cycles under random inputs.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      random_inputs();
      #1;
      check("reset_ctl", 32'(ctl()), 32'(C_RESET));
      tick();
    end
    check("reset_timeout", 32'(bus.mem_timeout), 32'd0);

    reset = 1'b1;
    idle_inputs();
    #1;
    check("run_idle", 32'(ctl()), 32'(C_RUN));
    check("run_timeout", 32'(bus.mem_timeout), 32'd0);
    tick();

    // Load-use on rs2 gives exactly one bubble.
    set_load_use(5'd5);
    #1;
    check("load_use_rs2", 32'(ctl()), 32'(C_LDUSE));
    tick();
    idle_inputs();
    #1;
    check("load_use_released", 32'(ctl()), 32'(C_RUN));
    tick();

    set_load_use(5'd0);
    bus.id_rs2 = 5'd0;
    #1;
    check("load_use_rd_zero", 32'(ctl()), 32'(C_RUN));
    tick();

    idle_inputs();
    bus.idex_memread = 1'b1;
    bus.idex_rd      = 5'd9;
    bus.id_rs1       = 5'd9;
    bus.id_rs1_used  = 1'b0;
    #1;
    check("rs1_unused_no_stall", 32'(ctl()), 32'(C_RUN));
    bus.id_rs1_used = 1'b1;
    #1;
    check("load_use_rs1", 32'(ctl()), 32'(C_LDUSE));
    tick();

    // Redirect squashes a coincident load-use.
    idle_inputs();
    set_load_use(5'd5);
    bus.ex_redirect = 1'b1;
    #1;
    check("redirect_over_load_use", 32'(ctl()), 32'(C_REDIR));
    tick();

    // Three frozen cycles, then the held branch flushes on release.
    idle_inputs();
    bus.ex_redirect  = 1'b1;
    bus.exmem_memreq = 1'b1;
    bus.dmem_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mem_wait_frozen", 32'(ctl()), 32'(C_FROZEN));
      tick();
    end
    bus.dmem_ready = 1'b1;
    #1;
    check("mem_wait_release_redirect", 32'(ctl()), 32'(C_REDIR));
    tick();
    idle_inputs();
    bus.dmem_ready = 1'b0;
    #1;
    check("back_in_run", 32'(ctl()), 32'(C_RUN));
    tick();

    // Mem stall beats load-use; load-use applies on the release cycle.
    idle_inputs();
    set_load_use(5'd5);
    bus.exmem_memreq = 1'b1;
    bus.dmem_ready   = 1'b0;
    #1;
    check("stall_over_load_use", 32'(ctl()), 32'(C_FROZEN));
    tick();
    bus.exmem_memreq = 1'b0;
    #1;
    check("wait_ignores_memreq", 32'(ctl()), 32'(C_FROZEN));
    tick();
    bus.dmem_ready = 1'b1;
    #1;
    check("release_load_use", 32'(ctl()), 32'(C_LDUSE));
    tick();

    // Watchdog: ERROR after four MEM_WAIT cycles, sticky until reset.
    idle_inputs();
    bus.exmem_memreq = 1'b1;
    bus.dmem_ready   = 1'b0;
    #1;
    check("timeout_entry", 32'(ctl()), 32'(C_FROZEN));
    tick();
    for (int i = 0; i < 4; i++) begin
      check("timeout_wait_ctl", 32'(ctl()), 32'(C_FROZEN));
      check("timeout_not_yet", 32'(bus.mem_timeout), 32'd0);
      tick();
    end
    check("timeout_set", 32'(bus.mem_timeout), 32'd1);
    idle_inputs();
    #1;
    check("error_ctl", 32'(ctl()), 32'(C_FROZEN));
    tick();
    check("timeout_sticky", 32'(bus.mem_timeout), 32'd1);
    check("error_hold_ctl", 32'(ctl()), 32'(C_FROZEN));
    reset = 1'b0;
    #1;
    check("error_reset_ctl", 32'(ctl()), 32'(C_RESET));
    tick();
    check("timeout_cleared", 32'(bus.mem_timeout), 32'd0);
    reset = 1'b1;
    #1;
    check("run_after_error", 32'(ctl()), 32'(C_RUN));
    tick();

`ifdef PIPE_PERF_CNT_EN
    // Counters saturate at all-ones for a 4-bit width.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("perf_stall_reset", 32'(stall_cycles), 32'd0);
    set_load_use(5'd5);
    for (int i = 0; i < 10; i++) tick();
    check("perf_stall_10", 32'(stall_cycles), 32'd10);
    for (int i = 0; i < 10; i++) tick();
    check("perf_stall_sat", 32'(stall_cycles), 32'd15);
    check("perf_flush_none", 32'(flush_events), 32'd0);
    bus.ex_redirect = 1'b1;
    tick();
    check("perf_flush_one", 32'(flush_events), 32'd1);
    idle_inputs();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
